// File: rtl/pulse_train_gen.sv
// Turns single-cycle request ticks into level pulses with captured high time and a guaranteed low gap.
// Latency 1 from an idle tick to signal_out high. Ticks during a pulse are queued in a saturating counter; overflow is sticky.
module pulse_train_gen #(
  parameter int LEN_W  = 8,
  parameter int PEND_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trigger_tick,
  input  logic [LEN_W-1:0]  high_len,
  input  logic [LEN_W-1:0]  low_len,
  output logic              signal_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  logic [1:0]       state;
  logic [LEN_W-1:0] hi_cnt;
  logic [LEN_W-1:0] lo_cnt;
  logic [LEN_W-1:0] lo_lat;
  logic [LEN_W-1:0] high_eff;
  logic [LEN_W-1:0] low_eff;
  logic             have_pend;
  logic             gap_done;
  logic             start;
  logic             consume;
  logic             queue_tick;

  always_comb begin
    high_eff   = (high_len == '0) ? LEN_ONE : high_len;
    low_eff    = (low_len  == '0) ? LEN_ONE : low_len;
    have_pend  = (pending != '0);
    gap_done   = (state == ST_GAP) && (lo_cnt == LEN_ONE);
    // An idle tick starts a pulse directly; a queued request can start one from IDLE or at GAP exit.
    start      = ((state == ST_IDLE) && (trigger_tick || have_pend)) || (gap_done && have_pend);
    consume    = start && have_pend;
    queue_tick = trigger_tick && ((state != ST_IDLE) || have_pend);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      signal_out <= 1'b0;
      busy       <= 1'b0;
      hi_cnt     <= '0;
      lo_cnt     <= '0;
      lo_lat     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_HIGH;
            signal_out <= 1'b1;
            busy       <= 1'b1;
            hi_cnt     <= high_eff;
            lo_lat     <= low_eff;
          end
        end
        ST_HIGH: begin
          if (hi_cnt == LEN_ONE) begin
            state      <= ST_GAP;
            signal_out <= 1'b0;
            lo_cnt     <= lo_lat;
          end else begin
            hi_cnt <= hi_cnt - LEN_ONE;
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            if (start) begin
              state      <= ST_HIGH;
              signal_out <= 1'b1;
              hi_cnt     <= high_eff;
              lo_lat     <= low_eff;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            lo_cnt <= lo_cnt - LEN_ONE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          signal_out <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      case ({queue_tick, consume})
        2'b10: begin
          if (pending == PEND_MAX) overflow <= 1'b1;
          else                     pending  <= pending + PEND_W'(1);
        end
        2'b01:   pending <= pending - PEND_W'(1);
        default: pending <= pending;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench: expected pulses (rise cycle, high width) are queued at stimulus time and checked by an edge monitor.
module tb_pulse_train_gen;

  logic       clk;
  logic       reset;
  logic       trigger_tick;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic       signal_out;
  logic       busy;
  logic [2:0] pending;
  logic       overflow;

  typedef struct {
    int rise;
    int width;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  pulse_train_gen #(.LEN_W(8), .PEND_W(3)) dut (
    .clk(clk), .reset(reset), .trigger_tick(trigger_tick),
    .high_len(high_len), .low_len(low_len),
    .signal_out(signal_out), .busy(busy), .pending(pending), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int rise, input int width);
    exp_t e;
    e.rise  = rise;
    e.width = width;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy !== 1'b0 || pending !== 3'd0) && n < 500) begin
      nc();
      n++;
    end
    chk(tag, (n < 500) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Edge monitor: every rising edge must match the head of the scoreboard in start cycle and width.
  logic prev_out = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    if (signal_out === 1'b1 && prev_out === 1'b0) begin
      rise_cyc = cyc;
      chk("unexpected_rise", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
    end else if (signal_out === 1'b0 && prev_out === 1'b1) begin
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rise_cycle", rise_cyc, e.rise);
        chk("high_width", cyc - rise_cyc, e.width);
      end
    end
    prev_out = signal_out;
  end

  initial begin
    int t;
    reset = 1'b1; trigger_tick = 1'b0; high_len = 8'd0; low_len = 8'd0;
    repeat (3) nc();
    chk("rst_signal_out", signal_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;
    nc();

    // T1: 3 high, 2 low; inputs changed mid-pulse must not matter
    high_len = 8'd3; low_len = 8'd2; trigger_tick = 1'b1; t = cyc;
    push(t + 1, 3);
    nc(); trigger_tick = 1'b0; high_len = 8'd7; low_len = 8'd6;
    chk("t1_out_lat1", signal_out, 1);
    repeat (3) nc();
    chk("t1_low_after", signal_out, 0);
    nc();
    chk("t1_busy_gap_end", busy, 1);
    nc();
    chk("t1_idle", busy, 0);
    drain("t1_drain");

    // T2: zero lengths act as 1
    high_len = 8'd0; low_len = 8'd0; trigger_tick = 1'b1; t = cyc;
    push(t + 1, 1);
    nc(); trigger_tick = 1'b0;
    chk("t2_high", signal_out, 1);
    nc();
    chk("t2_gap_out", signal_out, 0);
    chk("t2_gap_busy", busy, 1);
    nc();
    chk("t2_idle", busy, 0);
    drain("t2_drain");

    // T3: three back-to-back ticks queue up
    high_len = 8'd2; low_len = 8'd2; trigger_tick = 1'b1; t = cyc;
    push(t + 1, 2); push(t + 5, 2); push(t + 9, 2);
    nc(); nc(); nc(); trigger_tick = 1'b0;
    chk("t3_pending_peak", pending, 2);
    drain("t3_drain");

    // T4: 10 ticks during one long pulse saturate the queue
    high_len = 8'd20; low_len = 8'd1; trigger_tick = 1'b1; t = cyc;
    for (int k = 0; k < 8; k++) push(t + 1 + 21 * k, 20);
    repeat (10) nc();
    trigger_tick = 1'b0;
    chk("t4_pending_sat", pending, 7);
    chk("t4_overflow", overflow, 1);
    drain("t4_drain");
    chk("t4_overflow_sticky", overflow, 1);

    // T5: tick coincident with GAP exit while one request is queued
    high_len = 8'd2; low_len = 8'd2; trigger_tick = 1'b1; t = cyc;
    push(t + 1, 2); push(t + 5, 2); push(t + 9, 2);
    nc(); nc(); trigger_tick = 1'b0;
    chk("t5_pending_one", pending, 1);
    nc(); nc(); trigger_tick = 1'b1;
    nc(); trigger_tick = 1'b0;
    chk("t5_pending_kept", pending, 1);
    chk("t5_second_pulse", signal_out, 1);
    drain("t5_drain");

    // T6: reset mid-pulse with three queued requests
    high_len = 8'd10; low_len = 8'd2; trigger_tick = 1'b1; t = cyc;
    push(t + 1, 4);
    repeat (4) nc();
    trigger_tick = 1'b0;
    chk("t6_pending_three", pending, 3);
    reset = 1'b1;
    nc();
    reset = 1'b0;
    chk("t6_rst_out", signal_out, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_pending", pending, 0);
    chk("t6_rst_overflow", overflow, 0);
    nc();
    high_len = 8'd3; low_len = 8'd1; trigger_tick = 1'b1; t = cyc;
    push(t + 1, 3);
    nc(); trigger_tick = 1'b0;
    chk("t6_fresh_lat1", signal_out, 1);
    drain("t6_drain");

    repeat (5) nc();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
